// File: rtl/pwm_serializer.sv
// Free-running PWM: duty_cycle is latched at each period wrap, and signal is high while count < latched duty.
// Optional macro PWM_SERIALIZER_PRESCALE_EN makes each counter step last PRESCALE clocks.
module pwm_serializer #(
  parameter int PULSE_BITS = 10,
  parameter int PRESCALE   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PULSE_BITS-1:0] duty_cycle,
  output logic                  signal,
  output logic                  period_start
);

  // Power-up values let the block run with reset tied low.
  logic [PULSE_BITS-1:0] count_reg = '0;
  logic [PULSE_BITS-1:0] duty_reg  = '0;
  logic [PULSE_BITS-1:0] count_next;
  logic [PULSE_BITS-1:0] duty_next;
  logic                  tick;
  logic                  wrap;

`ifdef PWM_SERIALIZER_PRESCALE_EN
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc_reg = '0;

  assign tick = (presc_reg == PRESC_LAST);

  always_ff @(posedge clock) begin
    if (reset || tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 16'd1;
    end
  end
`else
  // PRESCALE is accepted but has no effect in this build.
  logic unused_prescale;
  assign unused_prescale = (PRESCALE > 0);
  assign tick = 1'b1;
`endif

  // The duty sampled on the wrap step governs the whole following period.
  assign wrap = tick && (count_reg == '1);

  always_comb begin
    count_next = count_reg;
    duty_next  = duty_reg;
    if (tick) begin
      count_next = count_reg + 1'b1;
    end
    if (wrap) begin
      duty_next = duty_cycle;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
      duty_reg  <= '0;
    end else begin
      count_reg <= count_next;
      duty_reg  <= duty_next;
    end
  end

  assign signal       = (count_reg < duty_reg);
  assign period_start = (count_reg == '0);

endmodule

// File: tb/tb_pwm_serializer.sv
// Randomised bench for pwm_serializer, checked against a clock-count reference model.
// Per-clock signal/period_start checks plus per-period high-time and period_start width checks.
module tb_pwm_serializer;

  localparam int PB = 10;
  localparam int PERIOD = 1 << PB;
`ifdef PWM_SERIALIZER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [PB-1:0] duty_cycle = '0;
  logic          signal;
  logic          period_start;

  pwm_serializer #(.PULSE_BITS(PB), .PRESCALE(P)) dut (
    .clock       (clock),
    .reset       (reset),
    .duty_cycle  (duty_cycle),
    .signal      (signal),
    .period_start(period_start)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: clocks elapsed since reset/power-up and the duty owning the current period.
  int t_clk = 0;
  int cur_duty = 0;
  int hi_cnt = 0;
  int ps_cnt = 0;
  bit period_valid = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, obs, exp, t_clk, $time);
    end
  endtask

  function automatic int model_pos();
    return (t_clk / P) % PERIOD;
  endfunction

  function automatic bit model_signal();
    return model_pos() < cur_duty;
  endfunction

  task automatic observe();
    check_eq("signal", int'(signal), int'(model_signal()));
    check_eq("period_start", int'(period_start), int'(model_pos() == 0));
    hi_cnt += int'(signal);
    ps_cnt += int'(period_start);
  endtask

  // Effect of the coming rising edge given the inputs just driven.
  task automatic advance(input logic rst, input int d);
    if (rst) begin
      t_clk = 0;
      cur_duty = 0;
      hi_cnt = 0;
      ps_cnt = 0;
      period_valid = 1'b1;
    end else begin
      if ((t_clk % P == P - 1) && (model_pos() == PERIOD - 1)) begin
        if (period_valid) begin
          check_eq("period_high_clocks", hi_cnt, P * cur_duty);
          check_eq("period_start_clocks", ps_cnt, P);
        end
        period_valid = 1'b1;
        hi_cnt = 0;
        ps_cnt = 0;
        cur_duty = d;
      end
      t_clk++;
    end
  endtask

  task automatic tick(input logic rst, input int d);
    @(negedge clock);
    observe();
    reset = rst;
    duty_cycle = PB'(d);
    advance(rst, d);
  endtask

  task automatic run(input int n, input int d);
    for (int i = 0; i < n; i++) tick(1'b0, d);
  endtask

  initial begin
    int len;
    int sel;
    int d;
    int budget;

    // Reset tied low from power-up.
    reset = 1'b0;
    duty_cycle = PB'(512);
    advance(1'b0, 512);
    run(3 * PERIOD * P - 1, 512);

    // Steady 900, then change to 100 mid-period.
    run(2 * PERIOD * P + (PERIOD * P) / 2, 900);
    run(2 * PERIOD * P, 100);

    // Boundary duties.
    run(PERIOD * P + 37, 0);
    run(2 * PERIOD * P, PERIOD - 1);

    // Reset for 3 clocks while the output is high.
    budget = 0;
    while (!(model_signal() && model_pos() > 50) && budget < 2 * PERIOD * P) begin
      tick(1'b0, 700);
      budget++;
    end
    check_eq("wait_signal_high_bound", int'(budget < 2 * PERIOD * P), 1);
    for (int i = 0; i < 3; i++) tick(1'b1, 700);
    run(3 * PERIOD * P, 700);

    // Random duty changes at random times.
    for (int i = 0; i < 5; i++) begin
      len = $urandom_range(2500, 300);
      sel = $urandom_range(3, 0);
      if (sel == 0) d = 0;
      else if (sel == 1) d = PERIOD - 1;
      else d = $urandom_range(PERIOD - 1, 0);
      run(len * P, d);
    end
    run(PERIOD * P, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_serializer.md
Name: pwm_serializer

Overview:
Free-running pulse-width modulator that converts an N-bit duty-cycle word into a single-bit PWM waveform.
Period is 2^PULSE_BITS counter steps; output is high for duty_cycle steps of each period.
Used by the audio path to turn a square-wave tone (duty 900 or 100 of 1024) into a 1-bit audio output.
Duty updates take effect only at period boundaries, so the waveform never glitches mid-period.

Parameters:
PULSE_BITS, 10, width of duty_cycle and of the period counter; period = 2^PULSE_BITS steps
PRESCALE, 1, clocks per counter step; used only when PWM_SERIALIZER_PRESCALE_EN is defined; legal range 1..65535

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
duty_cycle  input  PULSE_BITS  requested high-time in counter steps per period (0..2^PULSE_BITS-1)
signal  output  1  PWM output
period_start  output  1  high during the first counter step (count==0) of every period

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port order is clock, reset, duty_cycle, signal, period_start. Positional instantiation with the first four ports must work.
- State:
  - count: PULSE_BITS-bit period counter.
  - duty_q: PULSE_BITS-bit latched duty.
  - presc_cnt: prescale counter, present only with the macro.
- Power-up: all registers initialise to 0. The block must run correctly with reset tied low.
- Reset (reset=1 at a clock edge): count<=0, duty_q<=0, presc_cnt<=0. signal=0 and period_start=1 while held in reset and on the first cycle after release.
- Step enable "tick": always 1 without the macro.
- On each tick, count<=count+1, wrapping from 2^PULSE_BITS-1 to 0.
- On the tick where count==2^PULSE_BITS-1 (wrap), duty_q<=duty_cycle. The new duty governs the period that begins at count==0.
- duty_cycle changes at any other time are ignored until the next wrap. Only the value present on the wrap tick is used.
- signal = (count < duty_q). It is derived from registers only, with no combinational path from duty_cycle.
- Duty boundaries:
  - duty_q=0: signal constant 0.
  - duty_q=2^PULSE_BITS-1: signal high for all but the last step of the period.
  - duty_q=D: high for exactly D steps starting at count 0, low for the remaining 2^PULSE_BITS-D steps.
- After reset release, the first period uses duty_q=0, so signal is low. duty_cycle sampled at the end of that first period applies from the second period on.
- period_start = (count==0). Without the macro it is exactly one clock wide.
- Reset mid-period: takes priority over all updates. The period restarts from count 0 with duty_q=0.

Optional Feature:
- Macro: PWM_SERIALIZER_PRESCALE_EN.
- Defined:
  - A 16-bit presc_cnt counts 0..PRESCALE-1. tick=1 only when presc_cnt==PRESCALE-1, then presc_cnt wraps to 0.
  - count and duty_q update only on tick.
  - Period = PRESCALE*2^PULSE_BITS clocks; each step lasts PRESCALE clocks.
  - period_start is high for the PRESCALE clocks of step 0.
  - PRESCALE=1 behaves identically to the macro-undefined build.
- Undefined: no prescale logic; tick=1 every clock; the PRESCALE parameter is accepted but ignored.

Test Plan:
- Reset then hold duty_cycle=100 (PULSE_BITS=10) -> first period after reset all low; from the second period, signal high exactly 100 clocks, low 924 clocks, repeating every 1024 clocks; period_start pulses every 1024 clocks.
- duty_cycle=900 steady -> signal high 900 / low 124 per 1024-clock period. Then change to 100 mid-period -> current period completes at 900; the next period is 100 high.
- duty_cycle=0 -> signal never goes high. duty_cycle=1023 -> signal low exactly 1 clock per period (at count 1023).
- Reset tied low from power-up with duty_cycle=512 -> first period low; subsequent periods 512 high / 512 low.
- Assert reset for 3 clocks mid-period while signal is high -> signal 0 on the next edge; count restarts at 0; the following period is low (duty_q=0); normal duty resumes after that.
- Macro defined, PRESCALE=4, duty_cycle=2, PULSE_BITS=10 -> period 4096 clocks; signal high 8 clocks per period; period_start high 4 clocks per period.
